map_write_arbiter: RTL
======================

# map_write_arbiter

Arbitrates the single write port of the 256×8 map tile RAM between three sources: the SoC `map_write` export (Nios software, fire-and-forget pulses), a hardware game-logic requester using a req/ack handshake, and a built-in clear engine that fills the whole map with one value. It sits between `final_soc` and the map RAM in the top level. It buffers software writes in a small FIFO so that none are lost while the port is busy, and it drives the RAM through one registered write port.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: software write FIFO depth; must be a power of two, minimum 2.
- `LW`, default `$clog2(FIFO_DEPTH)+1`: width of `fifo_level`; derived, do not override.

Ports:
- `clk_clk`  in  1  system clock; one clock domain.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `sw_we`  in  1  software write strobe (from `map_write_enable`); one write per high cycle.
- `sw_addr`  in  8  software write address.
- `sw_data`  in  8  software write data.
- `sw_overflow`  out  1  sticky flag; set when a software write is dropped.
- `ovf_clr`  in  1  synchronous clear for `sw_overflow`.
- `fifo_level`  out  LW  number of entries currently in the FIFO.
- `gl_req`  in  1  game-logic write request; held until acked.
- `gl_addr`  in  8  game-logic address; stable while `gl_req` is high.
- `gl_data`  in  8  game-logic data; stable while `gl_req` is high.
- `gl_ack`  out  1  one-cycle acknowledge; the game-logic write has been issued.
- `clr_start`  in  1  start a full-map clear (pulse).
- `clr_value`  in  8  fill value; captured in the cycle `clr_start` is accepted.
- `clr_busy`  out  1  clear in progress.
- `ram_we`  out  1  map RAM write enable (registered).
- `ram_addr`  out  8  map RAM address (registered).
- `ram_data`  out  8  map RAM data (registered).

## Operation
- **States:** IDLE and CLEAR.
- **Reset:** state is IDLE, FIFO empty, and the clear counter is 0. All outputs are 0: `ram_we`, `ram_addr`, `ram_data`, `gl_ack`, `clr_busy`, `sw_overflow`, `fifo_level`. Asserting reset during CLEAR aborts the clear; unwritten addresses stay untouched.
- **FIFO push:** when `sw_we` is high in cycle C, `{sw_addr, sw_data}` is enqueued at the end of C.
  - If the FIFO is full and no pop happens in C, the write is dropped and `sw_overflow` is set.
  - If the FIFO is full and a pop happens in C, the push is accepted.
- **Push during CLEAR:** software pushes are still accepted during CLEAR and drain after the clear finishes. Software writes made during a clear therefore land on top of the cleared map.
- **`sw_overflow`:** `ovf_clr` clears it. If `ovf_clr` and a new overflow occur in the same cycle, set wins.
- **IDLE grant, evaluated each cycle, highest priority first:**
  1. FIFO non-empty: pop the head and write it.
  2. Otherwise, `gl_req` high and `gl_ack` currently low: write `gl_addr`/`gl_data` and raise `gl_ack` next cycle.
  3. Otherwise, `ram_we` is 0 next cycle.
- **Game-logic handshake:**
  - A request is never granted in a cycle where `gl_ack` is high, so the requester can drop or change its request after the ack.
  - Game-logic throughput is at most one write per 2 cycles.
  - A continuous FIFO stream can starve game logic; this is accepted because software writes are rare.
- **Starting a clear:** `clr_start` is honoured only in IDLE; it is ignored while `clr_busy` is high. In the start cycle C, the normal IDLE grant still happens. CLEAR begins in C+1 and `clr_value` is latched at the end of C.
- **CLEAR:**
  - Writes addresses 0x00 through 0xFF in ascending order, one per cycle, with the latched value.
  - No FIFO pops and no game-logic grants happen during CLEAR.
  - After address 0xFF is issued, the state returns to IDLE.
- **Widths:** the clear counter is 8 bits, and the clear ends on counter value 0xFF (no wrap). FIFO pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. `fifo_level` is computed as push minus pop.

## Timing
- **Software path:** `sw_we` high in cycle C, FIFO empty, no clear → `ram_we` high in C+2 with that address and data (latency 2).
- **Game-logic path:** `gl_req` first high in cycle C, FIFO empty, no clear → `ram_we` and `gl_ack` both high in C+1. The request is not regranted in C+1.
- **Clear path:** `clr_start` in C:
  - `clr_busy` is high from C+1 through C+257.
  - Clear writes appear on `ram_we` in C+2 through C+257, at address k in cycle C+2+k.
  - `clr_busy` is low in C+258, and normal grants resume with a first write visible in C+259.
- **`fifo_level`:** updates at the edge where the push or pop takes effect.
- **`ram_*` outputs:** `ram_addr` and `ram_data` hold their last value when `ram_we` is 0.

## Test plan
- **Reset:** assert reset mid-clear at k=0x40 → all outputs 0 immediately; no further `ram_we`; after release, state is IDLE and `fifo_level`=0.
- **Single software write:** `sw_we` with addr 0x12, data 0xA5 in cycle C → exactly one `ram_we` in C+2 with 0x12/0xA5.
- **Back-to-back software vs. game logic:** `sw_we` held for 3 cycles (addr 0x01–0x03) while `gl_req` is held (addr 0x80, data 0x7E):
  - the three software writes go out in order first;
  - the game-logic write follows, with one `gl_ack` pulse aligned to its `ram_we`;
  - no duplicate write to 0x80.
- **Overflow:** `clr_start`, then 5 `sw_we` pulses during CLEAR with `FIFO_DEPTH`=4 →
  - `fifo_level`=4 and `sw_overflow`=1;
  - after the clear, 4 writes drain in order;
  - `ovf_clr` then clears the flag.
- **Clear:** `clr_start` with `clr_value`=0x3C →
  - 256 consecutive writes, addresses 0x00–0xFF, all data 0x3C;
  - `clr_busy` lasts 257 cycles;
  - a second `clr_start` during the clear is ignored, and `gl_ack` is never asserted during the clear.
- **Simultaneous events:** FIFO full and popping while `sw_we` is high → the push is accepted, `fifo_level` stays 4, and `sw_overflow` stays 0.

Source files
------------

// File: rtl/map_write_arbiter.sv
// Single registered write port for the 256x8 map RAM, shared by buffered software
// writes, a req/ack game-logic requester and a full-map clear engine.
module map_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          sw_we,
  input  logic [7:0]    sw_addr,
  input  logic [7:0]    sw_data,
  output logic          sw_overflow,
  input  logic          ovf_clr,
  output logic [LW-1:0] fifo_level,
  input  logic          gl_req,
  input  logic [7:0]    gl_addr,
  input  logic [7:0]    gl_data,
  output logic          gl_ack,
  input  logic          clr_start,
  input  logic [7:0]    clr_value,
  output logic          clr_busy,
  output logic          ram_we,
  output logic [7:0]    ram_addr,
  output logic [7:0]    ram_data
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [7:0]      fifo_addr_r [FIFO_DEPTH];
  logic [7:0]      fifo_data_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [7:0]      clr_cnt_r, clr_val_r;
  logic            busy_r, ack_r, ovf_r, we_r;
  logic [7:0]      addr_r, data_r;

  logic            fifo_empty_s, fifo_full_s;
  logic            pop_s, push_s, drop_s, gl_grant_s, clr_accept_s;
  logic            we_s;
  logic [7:0]      addr_s, data_s;

  assign fifo_empty_s = (level_r == {LW{1'b0}});
  assign fifo_full_s  = (level_r == LW'(FIFO_DEPTH));
  assign push_s       = sw_we & (~fifo_full_s | pop_s);
  assign drop_s       = sw_we & fifo_full_s & ~pop_s;

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the clear ends once address 0xFF has been issued
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = clr_accept_s ? CLEAR : IDLE;
      CLEAR:   state_s = (clr_cnt_r == 8'hFF) ? IDLE : CLEAR;
      default: state_s = IDLE;
    endcase
  end

  // Grant selection and next write-port values. Grants stay off in the trailing
  // busy cycle after a clear so normal traffic restarts one cycle later.
  always_comb begin
    pop_s        = 1'b0;
    gl_grant_s   = 1'b0;
    clr_accept_s = 1'b0;
    we_s         = 1'b0;
    addr_s       = addr_r;
    data_s       = data_r;
    case (state_r)
      IDLE: begin
        if (!busy_r) begin
          clr_accept_s = clr_start;
          if (!fifo_empty_s) begin
            pop_s  = 1'b1;
            we_s   = 1'b1;
            addr_s = fifo_addr_r[rd_ptr_r];
            data_s = fifo_data_r[rd_ptr_r];
          end else if (gl_req && !ack_r) begin
            gl_grant_s = 1'b1;
            we_s       = 1'b1;
            addr_s     = gl_addr;
            data_s     = gl_data;
          end else begin
            we_s = 1'b0;
          end
        end else begin
          clr_accept_s = 1'b0;
        end
      end
      CLEAR: begin
        we_s   = 1'b1;
        addr_s = clr_cnt_r;
        data_s = clr_val_r;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by the pointers and level
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= sw_addr;
      fifo_data_r[wr_ptr_r] <= sw_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Clear engine counter/value and sticky overflow; a new drop beats ovf_clr
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      clr_cnt_r <= 8'h00;
      clr_val_r <= 8'h00;
      ovf_r     <= 1'b0;
    end else begin
      if (clr_accept_s) begin
        clr_cnt_r <= 8'h00;
        clr_val_r <= clr_value;
      end else if (state_r == CLEAR) begin
        clr_cnt_r <= clr_cnt_r + 8'h01;
      end
      if (drop_s)       ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      busy_r <= 1'b0;
      ack_r  <= 1'b0;
      we_r   <= 1'b0;
      addr_r <= 8'h00;
      data_r <= 8'h00;
    end else begin
      busy_r <= (state_s == CLEAR) || (state_r == CLEAR);
      ack_r  <= gl_grant_s;
      we_r   <= we_s;
      addr_r <= addr_s;
      data_r <= data_s;
    end
  end

  assign sw_overflow = ovf_r;
  assign fifo_level  = level_r;
  assign gl_ack      = ack_r;
  assign clr_busy    = busy_r;
  assign ram_we      = we_r;
  assign ram_addr    = addr_r;
  assign ram_data    = data_r;

endmodule
